// File: rtl/phase_sequencer.sv
// Phase sequencer: steps a one-hot phase enable through NPHASE phases per
// instruction. It can run continuously, or single-step one instruction per
// exec pulse. It counts advancing cycles and completed instructions, and it
// latches into HALTED when a halt decode arrives in the last phase.
module phase_sequencer #(
  parameter int NPHASE = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exec,
  input  logic              step_mode,
  input  logic              halt,
  input  logic              stall,
  output logic [NPHASE-1:0] phase,
  output logic [3:0]        phase_idx,
  output logic              running,
  output logic              halted,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  inst_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  localparam logic [NPHASE-1:0] PHASE_FIRST = {1'b1, {(NPHASE-1){1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

  state_e             state_q, state_d;
  logic [NPHASE-1:0]  phase_q, phase_d;
  logic [3:0]         phase_idx_q, phase_idx_d;
  logic               running_q, running_d;
  logic               halted_q, halted_d;
  logic               pause_q, pause_d;
  logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0]   inst_count_q, inst_count_d;
  logic               pause_pend;

  // Next-state and next-output logic for the sequencer FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can leave
    // one unassigned and infer a latch.
    state_d       = state_q;
    phase_d       = phase_q;
    phase_idx_d   = phase_idx_q;
    running_d     = running_q;
    halted_d      = halted_q;
    pause_d       = pause_q;
    cycle_count_d = cycle_count_q;
    inst_count_d  = inst_count_q;
    // An exec that arrives in the completing cycle of a RUN instruction still
    // counts as a pause request for that completion.
    pause_pend    = pause_q | exec;

    unique case (state_q)
      S_IDLE: begin
        pause_d = 1'b0;
        if (exec) begin
          // step_mode is looked at only here, on the way out of IDLE.
          state_d     = step_mode ? S_STEP : S_RUN;
          phase_d     = PHASE_FIRST;
          phase_idx_d = 4'd0;
          running_d   = 1'b1;
        end
      end

      S_RUN, S_STEP: begin
        if (exec && state_q == S_RUN) pause_d = 1'b1;
        if (!stall) begin
          if (cycle_count_q != CNT_MAX) cycle_count_d = cycle_count_q + CNT_ONE;
          if (phase_q[0]) begin
            if (inst_count_q != CNT_MAX) inst_count_d = inst_count_q + CNT_ONE;
            phase_idx_d = 4'd0;
            if (halt) begin
              // A halt has priority over a pending pause and over step mode.
              state_d   = S_HALTED;
              phase_d   = '0;
              running_d = 1'b0;
              halted_d  = 1'b1;
              pause_d   = 1'b0;
            end else if (state_q == S_STEP || pause_pend) begin
              state_d   = S_IDLE;
              phase_d   = '0;
              running_d = 1'b0;
              pause_d   = 1'b0;
            end else begin
              phase_d = PHASE_FIRST;
            end
          end else begin
            phase_d     = phase_q >> 1;
            phase_idx_d = phase_idx_q + 4'd1;
          end
        end
      end

      S_HALTED: begin
        // HALTED is left only through reset.
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Register all state and outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the pre-edge values and the update order does not matter.
    if (!rst_n) begin
      state_q       <= S_IDLE;
      phase_q       <= '0;
      phase_idx_q   <= 4'd0;
      running_q     <= 1'b0;
      halted_q      <= 1'b0;
      pause_q       <= 1'b0;
      cycle_count_q <= '0;
      inst_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      phase_idx_q   <= phase_idx_d;
      running_q     <= running_d;
      halted_q      <= halted_d;
      pause_q       <= pause_d;
      cycle_count_q <= cycle_count_d;
      inst_count_q  <= inst_count_d;
    end
  end

  assign phase       = phase_q;
  assign phase_idx   = phase_idx_q;
  assign running     = running_q;
  assign halted      = halted_q;
  assign cycle_count = cycle_count_q;
  assign inst_count  = inst_count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer. Two instances (NPHASE=5/CNT_W=16
// and NPHASE=3/CNT_W=4) share one set of inputs. Both are compared every
// cycle against a behavioural model that tracks a phase position, an active
// flag and saturating counts. Directed scenarios add constant expectations.
module tb_phase_sequencer;

  logic clk = 1'b0;
  logic rst_n, exec, step_mode, halt, stall;

  logic [4:0]  phase_a;
  logic [3:0]  idx_a;
  logic        running_a, halted_a;
  logic [15:0] cyc_a, inst_a;

  logic [2:0]  phase_b;
  logic [3:0]  idx_b;
  logic        running_b, halted_b;
  logic [3:0]  cyc_b, inst_b;

  int checks   = 0;
  int failures = 0;

  // Model state, one slot per instance: 0 = NPHASE 5, 1 = NPHASE 3.
  int m_n[2]    = '{5, 3};
  int m_max[2]  = '{65535, 15};
  bit m_act[2];
  bit m_stepping[2];
  bit m_halted[2];
  bit m_pend[2];
  int m_pos[2];
  int m_cyc[2];
  int m_inst[2];

  always #5 clk = ~clk;

  phase_sequencer #(.NPHASE(5), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .exec(exec), .step_mode(step_mode),
    .halt(halt), .stall(stall), .phase(phase_a), .phase_idx(idx_a),
    .running(running_a), .halted(halted_a), .cycle_count(cyc_a),
    .inst_count(inst_a)
  );

  phase_sequencer #(.NPHASE(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .exec(exec), .step_mode(step_mode),
    .halt(halt), .stall(stall), .phase(phase_b), .phase_idx(idx_b),
    .running(running_b), .halted(halted_b), .cycle_count(cyc_b),
    .inst_count(inst_b)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model of instance k by one clock edge using the current inputs.
  task automatic model_step(input int k);
    if (!rst_n) begin
      m_act[k] = 0; m_stepping[k] = 0; m_halted[k] = 0; m_pend[k] = 0;
      m_pos[k] = 0; m_cyc[k] = 0; m_inst[k] = 0;
      return;
    end
    if (m_halted[k]) return;
    if (!m_act[k]) begin
      m_pend[k] = 0;
      if (exec) begin
        m_act[k] = 1; m_stepping[k] = step_mode; m_pos[k] = 0;
      end
      return;
    end
    if (exec && !m_stepping[k]) m_pend[k] = 1;
    if (stall) return;
    if (m_cyc[k] < m_max[k]) m_cyc[k]++;
    if (m_pos[k] < m_n[k] - 1) begin
      m_pos[k]++;
      return;
    end
    if (m_inst[k] < m_max[k]) m_inst[k]++;
    if (halt) begin
      m_act[k] = 0; m_halted[k] = 1; m_pend[k] = 0;
    end else if (m_stepping[k] || m_pend[k]) begin
      m_act[k] = 0; m_pend[k] = 0;
    end else begin
      m_pos[k] = 0;
    end
  endtask

  function automatic int unsigned exp_phase(input int k);
    return m_act[k] ? (32'd1 << (m_n[k] - 1 - m_pos[k])) : 32'd0;
  endfunction

  // Drive inputs for one cycle, step the model, then compare after the edge.
  task automatic cycle(input bit e, input bit sm, input bit h, input bit st, input bit r);
    exec = e; step_mode = sm; halt = h; stall = st; rst_n = r;
    model_step(0);
    model_step(1);
    @(negedge clk);
    check("a.phase",   phase_a,   exp_phase(0));
    check("a.idx",     idx_a,     m_act[0] ? m_pos[0] : 0);
    check("a.running", running_a, m_act[0]);
    check("a.halted",  halted_a,  m_halted[0]);
    check("a.cycles",  cyc_a,     m_cyc[0]);
    check("a.insts",   inst_a,    m_inst[0]);
    check("b.phase",   phase_b,   exp_phase(1));
    check("b.idx",     idx_b,     m_act[1] ? m_pos[1] : 0);
    check("b.running", running_b, m_act[1]);
    check("b.halted",  halted_b,  m_halted[1]);
    check("b.cycles",  cyc_b,     m_cyc[1]);
    check("b.insts",   inst_b,    m_inst[1]);
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    exec = 0; step_mode = 0; halt = 0; stall = 0; rst_n = 0;
    @(negedge clk);

    // Reset state.
    do_reset();
    check("rst.phase", phase_a, 0);
    check("rst.running", running_a, 0);

    // Continuous run: one exec, twelve running cycles.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("run.first", phase_a, 5'b10000);
    for (int i = 1; i < 12; i++) begin
      idle_cycle();
      check("run.seq", phase_a, 32'd16 >> (i % 5));
      if (i == 10) check("run.inst10", inst_a, 2);
    end
    idle_cycle();
    check("run.cycles12", cyc_a, 12);
    do_reset();

    // Single step: exactly five phases, a second exec mid-step is ignored.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i < 5; i++) cycle(i == 2, 1'b1, 1'b0, 1'b0, 1'b1);
    check("step.last", phase_a, 5'b00001);
    idle_cycle();
    check("step.phase", phase_a, 0);
    check("step.running", running_a, 0);
    check("step.inst", inst_a, 1);
    idle_cycle();
    check("step.stays_idle", running_a, 0);
    do_reset();

    // Stall for three cycles in the middle phase.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_cycle();
    idle_cycle();
    check("stall.at", phase_a, 5'b00100);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("stall.hold", phase_a, 5'b00100);
    end
    check("stall.cycles", cyc_a, 2);
    idle_cycle();
    check("stall.resume", phase_a, 5'b00010);
    do_reset();

    // Halt is ignored before the last phase, honoured in it, and is sticky.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_cycle();
    idle_cycle();
    idle_cycle();
    check("halt.pre", phase_a, 5'b00010);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("halt.ignored", phase_a, 5'b00001);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("halt.halted", halted_a, 1);
    check("halt.phase", phase_a, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("halt.sticky", halted_a, 1);
    do_reset();
    check("halt.rst_cycles", cyc_a, 0);
    check("halt.rst_halted", halted_a, 0);

    // Pause: exec in the second phase finishes the instruction, then IDLE.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("pause.at", phase_a, 5'b01000);
    for (int i = 0; i < 3; i++) idle_cycle();
    check("pause.last", phase_a, 5'b00001);
    idle_cycle();
    check("pause.idle", running_a, 0);
    check("pause.inst", inst_a, 1);
    do_reset();

    // Saturation on the small instance, then reset in mid-phase.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 60; i++) idle_cycle();
    check("sat.inst", inst_b, 15);
    check("sat.cycles", cyc_b, 15);
    check("sat.running", running_b, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sat.rst_phase", phase_b, 0);
    check("sat.rst_inst", inst_b, 0);
    do_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 99) < 12,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) < 4,
            $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) >= 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
